// File: rtl/run_dump_controller_if.sv
// Memory read port and dump output stream between the run/dump controller and its neighbours.
// master = controller side, slave = memory / sink side.
interface run_dump_controller_if #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     mem_rd;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic [ADDRESS_WIDTH-1:0] out_addr;
    logic                     out_last;

    modport master (
        output mem_rd, mem_addr, out_valid, out_data, out_addr, out_last,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_rd, mem_addr, out_valid, out_data, out_addr, out_last,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/run_dump_controller.sv
// Run control for the datapath: run until halt or cycle limit, drain the pipeline,
// then stream a window of data memory out one word per read/wait/handshake round.
module run_dump_controller #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256,
    parameter int PIPE_DEPTH    = 5,
    parameter int CYCLE_WIDTH   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [CYCLE_WIDTH-1:0]   max_cycles_i,
    input  logic                     halt_req_i,
    input  logic [ADDRESS_WIDTH-1:0] dump_base_i,
    input  logic [ADDRESS_WIDTH:0]   dump_len_i,
    output logic                     core_en_o,
    output logic                     fetch_stall_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [CYCLE_WIDTH-1:0]   cycle_count_o,
    run_dump_controller_if.master    bus
);
    localparam int AW  = ADDRESS_WIDTH;
    localparam int DCW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, RUN, DRAIN, RD_REQ, RD_WAIT, OUT, DONE
    } state_t;

    state_t                 state_q;
    logic [CYCLE_WIDTH-1:0] max_q;
    logic [CYCLE_WIDTH-1:0] cycle_count_q;
    logic [AW-1:0]          base_q;
    logic [AW:0]            len_q;
    logic [AW:0]            idx_q;
    logic [DCW-1:0]         drain_q;
    logic                   core_en_q, fetch_stall_q, busy_q, done_q, timeout_q;
    logic                   mem_rd_q, out_valid_q, out_last_q;
    logic [AW-1:0]          mem_addr_q, out_addr_q;
    logic [DATA_WIDTH-1:0]  out_data_q;

    // One extra bit detects the all-ones saturation point and matches the limit compare.
    logic [CYCLE_WIDTH:0]   cnt_inc_d;
    logic [CYCLE_WIDTH-1:0] cnt_sat_d;
    logic [AW:0]            len_eff_d;

    always_comb begin
        cnt_inc_d = {1'b0, cycle_count_q} + (CYCLE_WIDTH+1)'(1);
        cnt_sat_d = cnt_inc_d[CYCLE_WIDTH] ? cycle_count_q : cnt_inc_d[CYCLE_WIDTH-1:0];
        len_eff_d = (dump_len_i > (AW+1)'(MEM_SIZE)) ? (AW+1)'(MEM_SIZE) : dump_len_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            max_q         <= '0;
            cycle_count_q <= '0;
            base_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            drain_q       <= '0;
            core_en_q     <= 1'b0;
            fetch_stall_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_addr_q    <= '0;
            out_last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q       <= RUN;
                        max_q         <= max_cycles_i;
                        base_q        <= dump_base_i;
                        len_q         <= len_eff_d;
                        cycle_count_q <= '0;
                        timeout_q     <= 1'b0;
                        idx_q         <= '0;
                        done_q        <= 1'b0;
                        busy_q        <= 1'b1;
                        core_en_q     <= 1'b1;
                        fetch_stall_q <= 1'b0;
                        out_last_q    <= 1'b0;
                    end
                end
                RUN: begin
                    cycle_count_q <= cnt_sat_d;
                    // Halt takes priority over the limit when both land in the same cycle.
                    if (halt_req_i) begin
                        state_q       <= DRAIN;
                        timeout_q     <= 1'b0;
                        fetch_stall_q <= 1'b1;
                        drain_q       <= '0;
                    end else if (max_q != '0 && cnt_inc_d == {1'b0, max_q}) begin
                        state_q       <= DRAIN;
                        timeout_q     <= 1'b1;
                        fetch_stall_q <= 1'b1;
                        drain_q       <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_q == DCW'(PIPE_DEPTH - 1)) begin
                        core_en_q     <= 1'b0;
                        fetch_stall_q <= 1'b0;
                        if (len_q == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= RD_REQ;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= base_q + idx_q[AW-1:0];
                        end
                    end else begin
                        drain_q <= drain_q + DCW'(1);
                    end
                end
                RD_REQ: begin
                    state_q  <= RD_WAIT;
                    mem_rd_q <= 1'b0;
                end
                RD_WAIT: begin
                    state_q     <= OUT;
                    out_data_q  <= bus.mem_rdata;
                    out_addr_q  <= mem_addr_q;
                    out_last_q  <= (idx_q == len_q - (AW+1)'(1));
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= RD_REQ;
                            idx_q      <= idx_q + (AW+1)'(1);
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= base_q + idx_q[AW-1:0] + AW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_en_o     = core_en_q;
    assign fetch_stall_o = fetch_stall_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign cycle_count_o = cycle_count_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_run_dump_controller.sv
// Bench for run_dump_controller: reference model queues expected dump words, a negedge monitor
// drives out_ready and checks every transferred word plus hold stability under backpressure.
module tb_run_dump_controller;
    localparam int DW = 20, AW = 8, MS = 256, PD = 5, CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [CW-1:0] max_cycles = '0;
    logic          halt = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          core_en, fetch_stall, busy, done, timeout;
    logic [CW-1:0] cycle_count;

    run_dump_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    run_dump_controller #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS), .PIPE_DEPTH(PD), .CYCLE_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .max_cycles_i(max_cycles),
        .halt_req_i(halt), .dump_base_i(base), .dump_len_i(len),
        .core_en_o(core_en), .fetch_stall_o(fetch_stall), .busy_o(busy), .done_o(done),
        .timeout_o(timeout), .cycle_count_o(cycle_count), .bus(bus)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          l;
    } word_t;

    logic [DW-1:0] mem [MS];
    word_t exp_q[$];
    int n_chk = 0, n_fail = 0;
    int rdy_mode = 0, words_seen = 0, hold_cnt = 0;
    logic  prev_pend = 1'b0;
    word_t prev_w = '0;

    // Synchronous-read memory: data appears the cycle after mem_rd.
    always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Ready is decided here so the transfer test uses exactly the value the next posedge samples.
    always @(negedge clk) begin : monitor
        logic  nr;
        word_t w, e;
        if (!rst_n) begin
            prev_pend     <= 1'b0;
            bus.out_ready <= 1'b0;
        end else begin
            case (rdy_mode)
                0:       nr = 1'b1;
                1:       nr = ($urandom % 4) != 0;
                2:       nr = !(bus.out_valid && words_seen == 1 && hold_cnt < 7);
                default: nr = 1'b0;
            endcase
            if (rdy_mode == 2 && bus.out_valid && words_seen == 1 && hold_cnt < 7)
                hold_cnt <= hold_cnt + 1;
            bus.out_ready <= nr;
            w.d = bus.out_data; w.a = bus.out_addr; w.l = bus.out_last;
            if (bus.out_valid && prev_pend) chk("hold_stable", w, prev_w);
            if (bus.out_valid && nr) begin
                words_seen <= words_seen + 1;
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", w);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", w, e);
                end
                prev_pend <= 1'b0;
            end else begin
                prev_pend <= bus.out_valid;
            end
            prev_w <= w;
        end
    end

    task automatic run_phase(input logic [CW-1:0] mx, input int hk, input logic [AW-1:0] b,
                             input logic [AW:0] l, input int mode, input bit poke,
                             output int ec, output bit et);
        int n, run_err, drain_err;
        word_t e;
        et = !(hk != 0 && (mx == 0 || hk <= int'(mx)));
        ec = et ? int'(mx) : hk;
        n  = (int'(l) > MS) ? MS : int'(l);
        for (int i = 0; i < n; i++) begin
            e.d = mem[(int'(b) + i) % MS];
            e.a = AW'(int'(b) + i);
            e.l = (i == n - 1);
            exp_q.push_back(e);
        end
        rdy_mode = mode; words_seen = 0; hold_cnt = 0;
        @(negedge clk);
        start = 1'b1; max_cycles = mx; base = b; len = l;
        @(negedge clk);
        start = 1'b0; max_cycles = $urandom; base = AW'($urandom); len = (AW+1)'($urandom);
        run_err = 0;
        for (int c = 1; c <= ec; c++) begin
            if (c > 1) @(negedge clk);
            if (!(core_en && !fetch_stall && busy && !done)) run_err++;
            halt = (c == hk);
            if (poke) begin
                start = (c == 3);
                if (c == 3) max_cycles = 2;
            end
        end
        @(negedge clk);
        halt = 1'b0; start = 1'b0;
        chk("run_cycles", run_err, 0);
        chk("cycle_count", cycle_count, ec);
        chk("timeout", timeout, et);
        drain_err = 0;
        for (int d = 1; d <= PD; d++) begin
            if (d > 1) @(negedge clk);
            if (!(core_en && fetch_stall && busy)) drain_err++;
        end
        chk("drain_cycles", drain_err, 0);
        @(negedge clk);
        chk("core_en_off", {core_en, fetch_stall}, 0);
    endtask

    task automatic wait_done(input int ec, input bit et);
        int t = 0;
        while (!done && t < 4000) begin
            @(negedge clk);
            halt = ($urandom % 2) == 1;
            t++;
        end
        halt = 1'b0;
        chk("done", {done, busy}, 2'b10);
        chk("queue_drained", exp_q.size(), 0);
        chk("count_held", cycle_count, ec);
        chk("timeout_held", timeout, et);
        chk("core_idle", {core_en, fetch_stall, bus.out_valid}, 0);
    endtask

    initial begin : stim
        int ec, t;
        bit et;
        logic [CW-1:0] mx;
        int hk;
        for (int i = 0; i < MS; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) mem[16 + i] = DW'(i + 1);

        #3;
        chk("reset_ctrl", {core_en, fetch_stall, busy, done, timeout, cycle_count}, 0);
        chk("reset_bus", {bus.mem_rd, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_addr, bus.out_last}, 0);
        @(negedge clk); rst_n = 1'b1;

        run_phase(0, 20, 8'h10, 4, 0, 0, ec, et);      wait_done(ec, et);  // halt stop
        run_phase(100, 0, 8'h33, 5, 1, 0, ec, et);     wait_done(ec, et);  // cycle limit
        run_phase(0, 7, 8'hFE, 3, 0, 0, ec, et);       wait_done(ec, et);  // address wrap
        run_phase(10, 0, 8'h80, 300, 0, 0, ec, et);    wait_done(ec, et);  // length clamp
        run_phase(0, 9, 8'h20, 5, 2, 0, ec, et);       wait_done(ec, et);  // backpressure
        run_phase(0, 4, 8'h55, 0, 0, 0, ec, et);       wait_done(ec, et);  // zero length
        run_phase(15, 15, 8'h05, 2, 0, 0, ec, et);     wait_done(ec, et);  // halt == limit
        run_phase(30, 0, 8'h90, 3, 1, 1, ec, et);      wait_done(ec, et);  // start during RUN

        // Async reset while a word is parked in OUT.
        run_phase(3, 0, 8'h40, 6, 3, 0, ec, et);
        t = 0;
        while (!bus.out_valid && t < 50) begin @(negedge clk); t++; end
        chk("reached_out", bus.out_valid, 1);
        repeat (20) @(negedge clk);
        chk("out_holds", {bus.out_valid, bus.out_addr}, {1'b1, 8'h40});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", {core_en, fetch_stall, busy, done, timeout, cycle_count}, 0);
        chk("async_reset_bus", {bus.mem_rd, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_addr, bus.out_last}, 0);
        exp_q.delete();
        rdy_mode = 0;
        @(negedge clk); rst_n = 1'b1;
        run_phase(0, 6, 8'h40, 6, 1, 0, ec, et);       wait_done(ec, et);

        for (int k = 0; k < 8; k++) begin
            mx = ($urandom % 2) ? CW'($urandom_range(1, 60)) : '0;
            hk = $urandom_range(0, 70);
            if (mx == 0 && hk == 0) hk = 5;
            run_phase(mx, hk, AW'($urandom), (AW+1)'($urandom_range(0, 20)), 1, 0, ec, et);
            wait_done(ec, et);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/run_dump_controller.md
Name: run_dump_controller

Overview:
- Synthesizable run-control and memory-dump unit that sits beside the pipelined datapath.
- Starts the core and stops it on a halt request or a programmable cycle limit.
- Drains the in-flight pipeline stages, then streams a programmable window of data memory out over a valid/ready port.
- Provides at the top level the run-for-N-cycles-then-dump-memory flow, parametrised in data width, memory depth, pipeline depth and counter width.

Parameters:
DATA_WIDTH, 20, data memory word width
ADDRESS_WIDTH, 8, data memory address width
MEM_SIZE, 256, data memory words; must equal 2**ADDRESS_WIDTH
PIPE_DEPTH, 5, drain cycles after stop (pipeline stages past fetch)
CYCLE_WIDTH, 32, width of cycle limit and cycle counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
max_cycles  in  CYCLE_WIDTH  run limit; 0 = unlimited; sampled on accepted start
halt_req  in  1  core halt request, level or pulse
dump_base  in  ADDRESS_WIDTH  first dump address; sampled on accepted start
dump_len  in  ADDRESS_WIDTH+1  words to dump; sampled on accepted start
core_en  out  1  datapath clock-enable
fetch_stall  out  1  forces bubbles into fetch (PC hold, NOP injected)
mem_rd  out  1  data memory read strobe
mem_addr  out  ADDRESS_WIDTH  data memory read address
mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd
out_valid  out  1  dump word valid
out_ready  in  1  sink ready
out_data  out  DATA_WIDTH  dump word
out_addr  out  ADDRESS_WIDTH  address of out_data
out_last  out  1  marks final dump word
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
timeout  out  1  run ended by max_cycles
cycle_count  out  CYCLE_WIDTH  cycles spent in RUN

Behaviour:
- Reset (rst low, asynchronous): state IDLE; every output 0; internal index 0. Applies mid-operation; any dump in progress is abandoned, no partial out_last.
- States: IDLE, RUN, DRAIN, RD_REQ, RD_WAIT, OUT, DONE.
- IDLE/DONE:
  - start -> RUN next cycle.
  - Latch max_cycles, dump_base and len_eff = min(dump_len, MEM_SIZE).
  - Clear cycle_count, timeout, index; done drops.
  - start ignored in all other states.
- RUN:
  - core_en=1, fetch_stall=0; cycle_count +1 per RUN cycle, saturating at all-ones.
  - halt_req=1 -> DRAIN, timeout=0.
  - Otherwise if max_cycles!=0 and cycle_count+1==max_cycles -> DRAIN, timeout=1.
  - Simultaneous halt and limit: halt wins, timeout=0.
- DRAIN:
  - core_en=1, fetch_stall=1 for exactly PIPE_DEPTH cycles so in-flight stores retire.
  - Then core_en=0 permanently until the next start.
  - Next state is RD_REQ, or DONE if len_eff==0.
- RD_REQ (1 cycle): mem_rd=1, mem_addr=(dump_base+index) mod MEM_SIZE (natural wrap) -> RD_WAIT.
- RD_WAIT (1 cycle): capture mem_rdata into out_data and the address into out_addr; out_last=(index==len_eff-1); -> OUT.
- OUT:
  - out_valid=1; out_data, out_addr and out_last held stable until handshake.
  - Transfer on out_valid&&out_ready. Next cycle out_valid=0.
  - If out_last -> DONE, else index+1 -> RD_REQ.
  - Throughput: at most 1 word per 3 cycles; no throughput requirement beyond that.
- DONE: done=1, busy=0, core_en=0; cycle_count and timeout held.
- halt_req outside RUN: ignored.
- out_ready low indefinitely: OUT holds; no timeout.

Test Plan:
- Halt stop: max_cycles=0, dump_base=0x10, dump_len=4, halt_req at RUN cycle 20, mem[0x10..0x13]=1,2,3,4.
  -> cycle_count=20, timeout=0, core_en high 5 more cycles with fetch_stall.
  -> out stream 1,2,3,4 at addrs 0x10..0x13, out_last on 4th, done=1.
- Cycle limit: max_cycles=100, no halt -> DRAIN after exactly 100 RUN cycles, cycle_count=100, timeout=1.
- Wrap and clamp:
  - dump_base=0xFE, dump_len=3 -> addresses 0xFE, 0xFF, 0x00.
  - dump_len=300 -> exactly 256 words, out_last at the 256th.
- Backpressure: out_ready low 7 cycles on word 2 -> out_data/out_addr stable, no word lost or duplicated.
- Corner inputs:
  - dump_len=0 -> DRAIN straight to DONE, no out_valid.
  - halt and limit in the same cycle -> timeout=0.
  - start during RUN -> ignored.
- Async reset: rst low mid-OUT between clock edges -> all outputs 0 immediately; restart after release completes a normal dump.
